tib_loader: RTL and testbench
=============================

# tib_loader

Console-side line writer for the eJ32 system. It accepts a byte stream from a host or UART receiver and writes one edited text line into the 8-bit shared memory at the terminal input buffer (TIB). It then terminates the line, publishes its length and holds until the core acknowledges. It is the producing end of the TIB path: the outer interpreter and the bench memory dump only read that region.

## Interface
- TIB, 'h1000, byte address of the input buffer in shared memory
- TIB_SZ, 'h100, buffer capacity in bytes, terminator included; power of two
- ASZ, 17, memory address width (128K space)
- clk  in  1  system clock; memory is clocked on ~clk
- rst  in  1  asynchronous, active-high reset
- rx_data_i  in  8  incoming character
- rx_valid_i  in  1  rx_data_i is valid
- rx_ready_o  out  1  loader can take a byte this cycle
- mem_req_o  out  1  request the shared memory port
- mem_gnt_i  in  1  port granted this cycle; the write completes in the same cycle
- mem_we_o  out  1  write strobe, equal to mem_req_o (the block never reads)
- mem_addr_o  out  ASZ  write address
- mem_data_o  out  8  write data
- line_rdy_o  out  1  a complete line is in the TIB; level signal, held until ack
- len_o  out  $clog2(TIB_SZ)  stored character count, terminator excluded; valid while line_rdy_o is high
- ovf_o  out  1  sticky: at least one character was dropped from this line
- tib_ack_i  in  1  core has consumed the line; re-arm

## Operation
- Internal index idx, $clog2(TIB_SZ) bits. Write address = TIB + idx, zero-extended to ASZ.
- States: INIT, IDLE, WR, TERM, DONE.
- INIT: entered on reset. Moves to IDLE on the next clock unconditionally.
- IDLE:
  - rx_ready_o = 1.
  - A byte is accepted on a cycle with rx_valid_i & rx_ready_o. What happens next depends on the byte.
  - 0x0d (CR): discarded; stay in IDLE.
  - 0x08 (BS) or 0x7f (DEL): if idx > 0 then idx--; no memory write; stay in IDLE.
  - 0x0a (LF): latch data = 0x00; go to TERM.
  - Any other byte, idx < TIB_SZ-1: latch the byte; go to WR.
  - Any other byte, idx = TIB_SZ-1: byte dropped; ovf_o set; stay in IDLE. The last slot is always reserved for the terminator.
- WR: mem_req_o = 1, data = latched byte. On mem_gnt_i: idx++, go to IDLE. Without grant: hold addr and data stable, stay in WR.
- TERM: mem_req_o = 1, data = 0x00 at TIB+idx. On mem_gnt_i: len_o = idx, line_rdy_o = 1, go to DONE.
- DONE: rx_ready_o = 0; line_rdy_o = 1. On tib_ack_i: idx = 0, len_o = 0, ovf_o = 0, line_rdy_o = 0, go to IDLE.
- tib_ack_i is ignored in every state except DONE.
- Memory outside [TIB, TIB+TIB_SZ) is never written. Stale bytes beyond the terminator are not cleared.

## Timing
- Reset values:
  - state = INIT; idx = 0.
  - rx_ready_o = 0, mem_req_o = 0, mem_we_o = 0.
  - mem_addr_o = TIB, mem_data_o = 0.
  - line_rdy_o = 0, len_o = 0, ovf_o = 0.
- rx_ready_o, mem_req_o and mem_we_o are decoded from the registered state. All other outputs are registers.
- First rx_ready_o = 1 is on the second clock edge after rst deasserts (INIT, then IDLE).
- Printable byte accepted at edge N: mem_we_o = 1 during cycle N+1. With grant in that cycle, rx_ready_o = 1 again from N+2. Throughput is one byte per 2 cycles.
- LF accepted at edge N: with grant during N+1, line_rdy_o = 1 from N+2.
- tib_ack_i sampled at edge M in DONE: rx_ready_o = 1 and line_rdy_o = 0 from M+1.
- Grant withheld for k cycles stretches WR or TERM by k cycles. rx_ready_o stays 0 throughout.
- Reset asserted mid-line: everything returns to reset values immediately. A write in flight is abandoned; memory contents are undefined at that one address.

## Test plan
- Bytes "2 3 +" then LF, grant tied 1:
  - TIB..TIB+5 = 32 20 33 20 2b 00.
  - len_o = 5, line_rdy_o rises 2 cycles after LF is accepted.
  - ovf_o = 0.
  - After ack, rx_ready_o = 1 and idx = 0.
- "ab", BS, "c", CR, LF:
  - TIB = 61 63 00; len_o = 2.
  - BS sent with idx = 0 leaves idx at 0.
- TIB_SZ = 'h10; send 20 copies of 'x', then LF:
  - TIB..TIB+e = 'x'; TIB+f = 00.
  - len_o = 'hf, ovf_o = 1. The ack clears ovf_o.
- mem_gnt_i held low for 5 cycles during the write of 'q':
  - mem_addr_o and mem_data_o remain stable; rx_ready_o stays 0.
  - The write occurs on the first granted cycle, then rx_ready_o = 1 on the next cycle.
- Assert rst between the accept of 'z' and its grant:
  - All outputs return to reset values asynchronously; no grant-time write occurs.
  - A new line after reset starts at TIB.
- rx_valid_i = 1 with LF while in DONE:
  - The byte is not taken (rx_ready_o = 0).
  - It is accepted on the cycle after ack, producing an empty line: TIB = 00, len_o = 0.

Source files
------------

// File: rtl/tib_loader.sv
// Console line writer: edits an incoming byte stream into the terminal input
// buffer, terminates it with 0x00, publishes the length and waits for the core.
module tib_loader #(
  parameter  int unsigned TIB    = 'h1000,
  parameter  int unsigned TIB_SZ = 'h100,
  parameter  int unsigned ASZ    = 17,
  localparam int unsigned IW     = $clog2(TIB_SZ)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data_i,
  input  logic           rx_valid_i,
  output logic           rx_ready_o,
  output logic           mem_req_o,
  input  logic           mem_gnt_i,
  output logic           mem_we_o,
  output logic [ASZ-1:0] mem_addr_o,
  output logic [7:0]     mem_data_o,
  output logic           line_rdy_o,
  output logic [IW-1:0]  len_o,
  output logic           ovf_o,
  input  logic           tib_ack_i
);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0a;
  localparam logic [7:0] CH_CR  = 8'h0d;
  localparam logic [7:0] CH_DEL = 8'h7f;
  localparam logic [IW-1:0] IDX_LAST = IW'(TIB_SZ - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_TERM,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [ASZ-1:0]  addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            rdy_q, rdy_d;
  logic [IW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      addr_q  <= ASZ'(TIB);
      data_q  <= '0;
      rdy_q   <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Line editing and write sequencing; the last slot is kept for the terminator.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == CH_CR) begin
            state_d = S_IDLE;
          end else if (rx_data_i == CH_BS || rx_data_i == CH_DEL) begin
            if (idx_q != '0) idx_d = idx_q - IW'(1);
          end else if (rx_data_i == CH_LF) begin
            data_d  = 8'h00;
            state_d = S_TERM;
          end else if (idx_q != IDX_LAST) begin
            data_d  = rx_data_i;
            state_d = S_WR;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (mem_gnt_i) begin
          idx_d   = idx_q + IW'(1);
          state_d = S_IDLE;
        end
      end
      S_TERM: begin
        if (mem_gnt_i) begin
          len_d   = idx_q;
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (tib_ack_i) begin
          idx_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          rdy_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Address register tracks the next index so it is stable during WR/TERM.
  assign addr_d = ASZ'(TIB) + ASZ'(idx_d);

  assign rx_ready_o = (state_q == S_IDLE);
  assign mem_req_o  = (state_q == S_WR) || (state_q == S_TERM);
  assign mem_we_o   = mem_req_o;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign line_rdy_o = rdy_q;
  assign len_o      = len_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_tib_loader.sv
// Bench for tib_loader: table of edited lines plus directed stall, reset and
// back-pressure sequences against a small TIB memory model.
module tb_tib_loader;

  localparam int unsigned TIB    = 'h1000;
  localparam int unsigned TIB_SZ = 'h10;
  localparam int unsigned ASZ    = 17;
  localparam int unsigned IW     = $clog2(TIB_SZ);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic           mem_req;
  logic           mem_gnt = 1'b1;
  logic           mem_we;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_data;
  logic           line_rdy;
  logic [IW-1:0]  len;
  logic           ovf;
  logic           tib_ack = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int oob    = 0;
  logic [7:0] tib_mem [TIB_SZ];

  tib_loader #(.TIB(TIB), .TIB_SZ(TIB_SZ), .ASZ(ASZ)) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .line_rdy_o(line_rdy), .len_o(len), .ovf_o(ovf), .tib_ack_i(tib_ack)
  );

  always #5 clk = ~clk;

  // Shared memory is clocked on the falling edge.
  always @(negedge clk) begin
    if (mem_we && mem_gnt) begin
      if (mem_addr >= ASZ'(TIB) && mem_addr < ASZ'(TIB + TIB_SZ))
        tib_mem[mem_addr - ASZ'(TIB)] <= mem_data;
      else
        oob <= oob + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_mem_req"},  32'(mem_req),  32'd0);
    chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
    chk({tag, "_addr"},     32'(mem_addr), 32'(TIB));
    chk({tag, "_data"},     32'(mem_data), 32'd0);
    chk({tag, "_line_rdy"}, 32'(line_rdy), 32'd0);
    chk({tag, "_len"},      32'(len),      32'd0);
    chk({tag, "_ovf"},      32'(ovf),      32'd0);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!rx_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rx_ready) chk("ready_timeout", 32'(rx_ready), 32'd1);
  endtask

  // Returns 1 ns after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    wait_ready();
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_ack();
    tib_ack = 1'b1;
    @(posedge clk); #1;
    tib_ack = 1'b0;
    chk("ack_rx_ready", 32'(rx_ready), 32'd1);
    chk("ack_line_rdy", 32'(line_rdy), 32'd0);
    chk("ack_len",      32'(len),      32'd0);
    chk("ack_ovf",      32'(ovf),      32'd0);
  endtask

  // seq must end in LF; exp is the stored text in front of the terminator.
  task automatic run_line(input string seq, input string exp, input bit exp_ovf, input bit ack);
    for (int i = 0; i < seq.len(); i++) send_byte(seq[i]);
    @(negedge clk);
    chk("term_line_rdy_early", 32'(line_rdy), 32'd0);
    chk("term_we",   32'(mem_we),   32'd1);
    chk("term_addr", 32'(mem_addr), 32'(TIB + exp.len()));
    chk("term_data", 32'(mem_data), 32'd0);
    @(negedge clk);
    chk("line_rdy", 32'(line_rdy), 32'd1);
    chk("len",      32'(len),      32'(exp.len()));
    chk("ovf",      32'(ovf),      32'(exp_ovf));
    for (int i = 0; i < exp.len(); i++) chk("tib_byte", 32'(tib_mem[i]), 32'(exp[i]));
    chk("tib_term", 32'(tib_mem[exp.len()]), 32'd0);
    if (ack) do_ack();
  endtask

  typedef struct {
    string seq;
    string exp;
    bit    ovf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{seq: "2 3 +\012", exp: "2 3 +", ovf: 1'b0};
    vecs[1] = '{seq: "\010ab\010c\015\012", exp: "ac", ovf: 1'b0};
    vecs[2] = '{seq: "xy\177\177\177z\012", exp: "z", ovf: 1'b0};
    vecs[3] = '{seq: "xxxxxxxxxxxxxxxxxxxx\012", exp: "xxxxxxxxxxxxxxx", ovf: 1'b1};
    vecs[4] = '{seq: "\012", exp: "", ovf: 1'b0};

    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("second_edge_rx_ready", 32'(rx_ready), 32'd1);

    for (int v = 0; v < 5; v++) run_line(vecs[v].seq, vecs[v].exp, vecs[v].ovf, 1'b1);

    // Grant withheld for five cycles during the write of 'q'.
    mem_gnt = 1'b0;
    send_byte("q");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_we",       32'(mem_we),     32'd1);
      chk("stall_addr",     32'(mem_addr),   32'(TIB));
      chk("stall_data",     32'(mem_data),   32'h71);
      chk("stall_rx_ready", 32'(rx_ready),   32'd0);
      chk("stall_no_write", 32'(tib_mem[0]), 32'd0);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk); #1;
    chk("stall_write", 32'(tib_mem[0]), 32'h71);
    @(posedge clk); #1;
    chk("stall_rx_ready_after", 32'(rx_ready), 32'd1);
    run_line("\012", "q", 1'b0, 1'b1);

    // Reset between accept of 'z' and its grant abandons the write.
    mem_gnt = 1'b0;
    send_byte("z");
    chk("z_we", 32'(mem_we), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset("midrst");
    mem_gnt = 1'b1;
    @(negedge clk); #1;
    chk("midrst_no_write", 32'(tib_mem[0]), 32'h71);
    @(posedge clk); #1;
    rst = 1'b0;
    run_line("k\012", "k", 1'b0, 1'b1);

    // LF presented while DONE is held off until after the ack.
    run_line("m\012", "m", 1'b0, 1'b0);
    rx_data  = 8'h0a;
    rx_valid = 1'b1;
    tib_ack  = 1'b1;
    chk("ack_in_idle_ignored", 32'(line_rdy), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tib_ack = 1'b0;
      @(negedge clk);
      chk("done_rx_ready", 32'(rx_ready), 32'd0);
      chk("done_line_rdy", 32'(line_rdy), 32'd1);
      chk("done_len",      32'(len),      32'd1);
      @(posedge clk); #1;
    end
    tib_ack = 1'b1;
    @(posedge clk); #1;
    tib_ack = 1'b0;
    chk("reack_rx_ready", 32'(rx_ready), 32'd1);
    chk("reack_line_rdy", 32'(line_rdy), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("empty_term_we",   32'(mem_we),   32'd1);
    chk("empty_term_addr", 32'(mem_addr), 32'(TIB));
    @(posedge clk); #1;
    chk("empty_line_rdy", 32'(line_rdy), 32'd1);
    chk("empty_len",      32'(len),      32'd0);
    chk("empty_tib0",     32'(tib_mem[0]), 32'd0);
    do_ack();

    chk("out_of_range_writes", 32'(oob), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
